// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the EX-stage ALU control sequencer.
//   - 4-bit ALU control codes (base RV32I ops and M-extension ops)
//   - ALUOp codes produced by the main decoder
//   - funct7 constants and the sequencer FSM state type
package alu_ctrl_pkg;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SRA  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;
    localparam logic [3:0] C_MUL  = 4'b1010;
    localparam logic [3:0] C_MULH = 4'b1011;
    localparam logic [3:0] C_DIV  = 4'b1100;
    localparam logic [3:0] C_DIVU = 4'b1101;
    localparam logic [3:0] C_REM  = 4'b1110;
    localparam logic [3:0] C_REMU = 4'b1111;

    localparam logic [1:0] OP_ADDR   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_RTYPE  = 2'b10;
    localparam logic [1:0] OP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Base-ISA funct3 mapping shared by R-type (funct7=0) and I-type ALU ops.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            3'b000:  c = C_ADD;
            3'b001:  c = C_SLL;
            3'b010:  c = C_SLT;
            3'b011:  c = C_SLTU;
            3'b100:  c = C_XOR;
            3'b101:  c = C_SRL;
            3'b110:  c = C_OR;
            default: c = C_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_dec.sv
// alu_ctrl_dec: combinational ALUOp/funct3/funct7 decode.
//   aluop_i, funct3_i, funct7_i : instruction fields
//   ctrl_o    : 4-bit ALU control code (ADD when illegal)
//   is_mdu_o  : op goes to the multiply/divide unit
//   is_div_o  : MDU op is a divide/remainder (selects divide latency)
//   illegal_o : encoding unsupported
module alu_ctrl_dec
    import alu_ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] ctrl_o,
    output logic       is_mdu_o,
    output logic       is_div_o,
    output logic       illegal_o
);

    logic [3:0] ctrl;
    logic       mdu;
    logic       div;
    logic       ill;

    always_comb begin
        ctrl = C_ADD;
        mdu  = 1'b0;
        div  = 1'b0;
        ill  = 1'b0;
        case (aluop_i)
            OP_ADDR:   ctrl = C_ADD;
            OP_BRANCH: ctrl = C_SUB;
            OP_RTYPE: begin
                case (funct7_i)
                    F7_BASE: ctrl = base_op(funct3_i);
                    F7_ALT: begin
                        if (funct3_i == 3'b000)      ctrl = C_SUB;
                        else if (funct3_i == 3'b101) ctrl = C_SRA;
                        else                         ill  = 1'b1;
                    end
                    F7_MULDIV: begin
                        // funct3 1xx -> DIV/DIVU/REM/REMU, 00x -> MUL/MULH, 01x unsupported
                        if (!EN_M || funct3_i[2:1] == 2'b01) begin
                            ill = 1'b1;
                        end else begin
                            ctrl = funct3_i[2] ? {2'b11, funct3_i[1:0]} : {3'b101, funct3_i[0]};
                            mdu  = 1'b1;
                            div  = funct3_i[2];
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 only qualifies the shifts
                if (funct3_i == 3'b001) begin
                    if (funct7_i == F7_BASE) ctrl = C_SLL;
                    else                     ill  = 1'b1;
                end else if (funct3_i == 3'b101) begin
                    if (funct7_i == F7_BASE)     ctrl = C_SRL;
                    else if (funct7_i == F7_ALT) ctrl = C_SRA;
                    else                         ill  = 1'b1;
                end else begin
                    ctrl = base_op(funct3_i);
                end
            end
        endcase
        if (ill) begin
            ctrl = C_ADD;
            mdu  = 1'b0;
            div  = 1'b0;
        end
    end

    assign ctrl_o    = ctrl;
    assign is_mdu_o  = mdu;
    assign is_div_o  = div;
    assign illegal_o = ill;

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with multi-cycle MUL/DIV sequencing.
//   clk_i, rst_i          : clock, async active-high reset
//   valid_i               : decode request (ignored while stall_o)
//   funct3_i/funct7_i/ALUOp_i : instruction fields
//   flush_i               : synchronous abort, wins over valid_i
//   ALUCtrl_o             : registered control code
//   valid_o               : result complete this cycle
//   mdu_sel_o             : op routed to the MDU
//   illegal_o             : accepted encoding unsupported
//   stall_o               : upstream must hold
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter bit EN_M    = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              valid_o,
    output logic              mdu_sel_o,
    output logic              illegal_o,
    output logic              stall_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [3:0] dec_ctrl;
    logic       dec_mdu;
    logic       dec_div;
    logic       dec_ill;

    alu_ctrl_dec #(.EN_M(EN_M)) u_dec (
        .aluop_i   (ALUOp_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .ctrl_o    (dec_ctrl),
        .is_mdu_o  (dec_mdu),
        .is_div_o  (dec_div),
        .illegal_o (dec_ill)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                mdu_q, mdu_d;
    logic                ill_q, ill_d;
    logic                vld_q, vld_d;   // single-cycle completion flag
    logic                accept;

    assign stall_o   = (state_q == BUSY) && (cnt_q != '0);
    assign valid_o   = vld_q || ((state_q == BUSY) && (cnt_q == '0));
    assign ALUCtrl_o = ctrl_q;
    assign mdu_sel_o = mdu_q;
    assign illegal_o = ill_q;
    assign accept    = valid_i && !stall_o && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            mdu_q   <= 1'b0;
            ill_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            mdu_q   <= mdu_d;
            ill_q   <= ill_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        mdu_d   = mdu_q;
        ill_d   = ill_q;
        vld_d   = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            mdu_d   = 1'b0;
            ill_d   = 1'b0;
        end else if (accept) begin
            ctrl_d = CTRL_W'(dec_ctrl);
            mdu_d  = dec_mdu;
            ill_d  = dec_ill;
            if (dec_mdu) begin
                // Also covers back-to-back M ops: BUSY at count 0 reloads directly
                state_d = BUSY;
                cnt_d   = dec_div ? DIV_LOAD : MUL_LOAD;
            end else begin
                state_d = IDLE;
                vld_d   = 1'b1;
            end
        end else if (state_q == BUSY) begin
            if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
            else             state_d = IDLE;
        end
    end

endmodule
